// File: rtl/i2c_cmd_dispatcher.sv
// Purpose: queues I2C slave frames and dispatches them as register writes or trigger pulses.
// Latency: 3 cycles from the synchronized rcv_succ rising edge to reg_wr_en (push, pop/decode, issue).
// Backpressure: the frame FIFO drops arrivals when full (sticky overflow); a write waits on reg_ack up to ACK_TIMEOUT cycles.
module i2c_cmd_dispatcher #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rcv_succ,
  input  logic [7:0]  command,
  input  logic [15:0] data,
  output logic        reg_wr_en,
  output logic [3:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic        reg_ack,
  output logic        trig,
  output logic [15:0] trig_code,
  output logic        busy,
  output logic        overflow,
  output logic        err
);

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] dat;
  } frame_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DECODE   = 2'd1,
    ISSUE    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [AW:0]   FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  // Capture side
  logic   rcv_meta;
  logic   rcv_sync;
  logic   rcv_sync_d;
  logic   push_vld;
  frame_t push_dat;

  // Frame FIFO
  frame_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     fifo_cnt;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push_ok;
  logic            pop_rdy;
  frame_t          head_dat;

  // Dispatch side
  state_t          state;
  frame_t          cur;
  logic [TW-1:0]   tmo_cnt;
  logic            ack_seen;

  assign push_vld   = rcv_sync & ~rcv_sync_d;
  assign push_dat   = '{cmd: command, dat: data};
  // Fullness is judged on the count at the start of the cycle, so a
  // simultaneous pop never rescues a push into a full FIFO.
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_cnt == '0);
  assign push_ok    = push_vld & ~fifo_full;
  assign pop_rdy    = (state == IDLE) & ~fifo_empty;
  assign head_dat   = fifo_mem[rd_ptr];
  assign busy       = (state != IDLE) | ~fifo_empty;

  // Bring rcv_succ into the clk domain and keep one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rcv_meta   <= 1'b0;
      rcv_sync   <= 1'b0;
      rcv_sync_d <= 1'b0;
    end else begin
      rcv_meta   <= rcv_succ;
      rcv_sync   <= rcv_meta;
      rcv_sync_d <= rcv_sync;
    end
  end

  // Sticky drop flag: a frame arrived while all FIFO slots were occupied
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push_vld && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_rdy) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_rdy})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_dat;
    end
  end

  // Dispatch FSM: one frame at a time, all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      tmo_cnt   <= '0;
      ack_seen  <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      trig      <= 1'b0;
      trig_code <= '0;
      err       <= 1'b0;
    end else begin
      trig <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur   <= head_dat;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= IDLE;
          if (cur.cmd[7:4] == 4'hA) begin
            reg_addr  <= cur.cmd[3:0];
            reg_wdata <= cur.dat;
            state     <= ISSUE;
          end else if (cur.cmd[7:4] == 4'h5) begin
            trig      <= 1'b1;
            trig_code <= cur.dat;
          end else if (cur.cmd != 8'h00) begin
            err <= 1'b1;
          end
        end
        ISSUE: begin
          reg_wr_en <= 1'b1;
          tmo_cnt   <= '0;
          ack_seen  <= 1'b0;
          state     <= WAIT_ACK;
        end
        WAIT_ACK: begin
          // The ack is registered first, so the strobe drops one cycle after it is seen
          if (ack_seen) begin
            reg_wr_en <= 1'b0;
            ack_seen  <= 1'b0;
            state     <= IDLE;
          end else if (reg_ack) begin
            ack_seen <= 1'b1;
          end else if (tmo_cnt == TMO_LAST) begin
            reg_wr_en <= 1'b0;
            err       <= 1'b1;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_cmd_dispatcher.sv
// Directed bench for i2c_cmd_dispatcher: write, trigger, NOP, overflow,
// ack timeout, reset during a pending write, and an illegal opcode.
// A passive monitor logs writes, pulse lengths and trigger pulses.
module tb_i2c_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        rcv_succ = 1'b0;
  logic [7:0]  command = '0;
  logic [15:0] data = '0;
  logic        reg_ack = 1'b0;
  logic        reg_wr_en;
  logic [3:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        trig;
  logic [15:0] trig_code;
  logic        busy;
  logic        overflow;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  i2c_cmd_dispatcher #(.FIFO_DEPTH(4), .ACK_TIMEOUT(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .rcv_succ  (rcv_succ),
    .command   (command),
    .data      (data),
    .reg_wr_en (reg_wr_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_ack   (reg_ack),
    .trig      (trig),
    .trig_code (trig_code),
    .busy      (busy),
    .overflow  (overflow),
    .err       (err)
  );

  // Monitor, sampled 1 time unit after each rising edge
  int          cyc = 0;
  int          wr_count = 0;
  int          trig_count = 0;
  int          unstable = 0;
  int          cur_len = 0;
  int          wr_rise_cyc = 0;
  logic        prev_wr = 1'b0;
  logic [3:0]  hold_addr = '0;
  logic [15:0] hold_wdata = '0;
  logic [15:0] last_trig_code = '0;
  logic [3:0]  addr_q [$];
  logic [15:0] wdat_q [$];
  int          len_q [$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reg_wr_en === 1'b1) begin
      if (!prev_wr) begin
        wr_count++;
        wr_rise_cyc = cyc;
        addr_q.push_back(reg_addr);
        wdat_q.push_back(reg_wdata);
        hold_addr  = reg_addr;
        hold_wdata = reg_wdata;
        cur_len    = 0;
      end else if (reg_addr !== hold_addr || reg_wdata !== hold_wdata) begin
        unstable++;
      end
      cur_len++;
    end else if (prev_wr) begin
      len_q.push_back(cur_len);
    end
    if (trig === 1'b1) begin
      trig_count++;
      last_trig_code = trig_code;
    end
    prev_wr = (reg_wr_en === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold rcv_succ long enough to cross the synchronizer, then release it
  task automatic send_frame(input logic [7:0] cmd, input logic [15:0] dat);
    command  = cmd;
    data     = dat;
    rcv_succ = 1'b1;
    tick(4);
    rcv_succ = 1'b0;
    tick(4);
  endtask

  int c0;
  int wc;
  int lb;

  initial begin
    rst = 1'b1;
    tick(3);
    check("rst_wr_en",     32'(reg_wr_en), 0);
    check("rst_trig",      32'(trig), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_overflow",  32'(overflow), 0);
    check("rst_err",       32'(err), 0);
    check("rst_addr",      32'(reg_addr), 0);
    check("rst_wdata",     32'(reg_wdata), 0);
    check("rst_trig_code", 32'(trig_code), 0);
    rst = 1'b0;
    tick(2);

    // Write with ack tied high
    reg_ack = 1'b1;
    c0 = cyc;
    send_frame(8'hA3, 16'h1234);
    tick(10);
    check("wr_count",   wr_count, 1);
    check("wr_latency", wr_rise_cyc - c0, 6);
    check("wr_q_size",  addr_q.size(), 1);
    if (addr_q.size() >= 1) begin
      check("wr_addr",  32'(addr_q[0]), 3);
      check("wr_wdata", 32'(wdat_q[0]), 32'h1234);
    end
    check("wr_len_size", len_q.size(), 1);
    if (len_q.size() >= 1) check("wr_len", len_q[0], 2);
    check("wr_err",  32'(err), 0);
    check("wr_busy", 32'(busy), 0);
    check("wr_trig", trig_count, 0);

    // Trigger
    send_frame(8'h51, 16'hBEEF);
    tick(10);
    check("trig_count", trig_count, 1);
    check("trig_code",  32'(last_trig_code), 32'hBEEF);
    check("trig_no_wr", wr_count, 1);
    check("trig_err",   32'(err), 0);
    check("trig_busy",  32'(busy), 0);

    // NOP is discarded silently
    send_frame(8'h00, 16'h5555);
    tick(10);
    check("nop_no_wr",   wr_count, 1);
    check("nop_no_trig", trig_count, 1);
    check("nop_err",     32'(err), 0);
    check("nop_busy",    32'(busy), 0);

    // Overflow: 1 in dispatch, 4 queued, the sixth frame dropped
    reg_ack = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      send_frame(8'hA0 | 8'(i), 16'(i));
    end
    tick(2);
    check("ovf_flag",      32'(overflow), 1);
    check("ovf_wr_count",  wr_count, 2);
    check("ovf_busy",      32'(busy), 1);
    check("ovf_wr_en",     32'(reg_wr_en), 1);
    check("ovf_held_addr", 32'(reg_addr), 1);
    reg_ack = 1'b1;
    tick(60);
    check("ovf_drain_count", wr_count, 6);
    check("ovf_q_size", addr_q.size(), 6);
    for (int k = 1; k <= 5; k++) begin
      if (addr_q.size() > k) begin
        check("ovf_order_addr",  32'(addr_q[k]), 32'(k));
        check("ovf_order_wdata", 32'(wdat_q[k]), 32'(k));
      end
    end
    check("ovf_err",      32'(err), 0);
    check("ovf_busy_end", 32'(busy), 0);
    check("ovf_sticky",   32'(overflow), 1);
    check("ovf_unstable", unstable, 0);

    // Ack timeout, with a second frame queued behind it
    reg_ack = 1'b0;
    lb = len_q.size();
    send_frame(8'hA0, 16'h00C0);
    send_frame(8'hA2, 16'h0022);
    tick(300);
    check("tmo_wr_count", wr_count, 8);
    check("tmo_len_size", len_q.size(), lb + 1);
    if (len_q.size() > lb) check("tmo_len", len_q[lb], 255);
    check("tmo_err", 32'(err), 1);
    if (addr_q.size() >= 8) begin
      check("tmo_first_addr",  32'(addr_q[6]), 0);
      check("tmo_first_wdata", 32'(wdat_q[6]), 32'h00C0);
    end
    check("tmo_next_wr_en", 32'(reg_wr_en), 1);
    check("tmo_next_addr",  32'(reg_addr), 2);
    check("tmo_next_wdata", 32'(reg_wdata), 32'h0022);
    reg_ack = 1'b1;
    tick(10);
    check("tmo_done_wr_en", 32'(reg_wr_en), 0);
    check("tmo_done_busy",  32'(busy), 0);

    // Reset while a write waits for ack and two frames are queued
    reg_ack = 1'b0;
    send_frame(8'hA4, 16'h0044);
    send_frame(8'hA5, 16'h0055);
    send_frame(8'hA6, 16'h0066);
    check("rmid_pre_wr_en", 32'(reg_wr_en), 1);
    check("rmid_pre_busy",  32'(busy), 1);
    rst = 1'b1;
    #1;
    check("rmid_wr_en",     32'(reg_wr_en), 0);
    check("rmid_trig",      32'(trig), 0);
    check("rmid_busy",      32'(busy), 0);
    check("rmid_overflow",  32'(overflow), 0);
    check("rmid_err",       32'(err), 0);
    check("rmid_addr",      32'(reg_addr), 0);
    check("rmid_wdata",     32'(reg_wdata), 0);
    check("rmid_trig_code", 32'(trig_code), 0);
    tick(3);
    rst = 1'b0;
    reg_ack = 1'b1;
    wc = wr_count;
    tick(20);
    check("rpost_busy",  32'(busy), 0);
    check("rpost_no_wr", wr_count, wc);
    check("rpost_wr_en", 32'(reg_wr_en), 0);

    // Illegal opcode
    send_frame(8'h77, 16'h1234);
    tick(10);
    check("ill_err",     32'(err), 1);
    check("ill_no_wr",   wr_count, wc);
    check("ill_no_trig", trig_count, 1);
    check("ill_busy",    32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_cmd_dispatcher.md
I2C_CMD_DISPATCHER -- requirements
Module: i2c_cmd_dispatcher

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of queued frames (power of two).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum cycles spent waiting for reg_ack.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rcv_succ, input, 1 bit: frame-received flag from the I2C slave (SCL domain, asynchronous to clk).
REQ-006 The block SHALL have port command, input, 8 bits: received command byte, stable while rcv_succ is high.
REQ-007 The block SHALL have port data, input, 16 bits: received data word, stable while rcv_succ is high.
REQ-008 The block SHALL have port reg_wr_en, output, 1 bit: register-write request.
REQ-009 The block SHALL have port reg_addr, output, 4 bits: register address.
REQ-010 The block SHALL have port reg_wdata, output, 16 bits: register write data.
REQ-011 The block SHALL have port reg_ack, input, 1 bit: the target accepted the write.
REQ-012 The block SHALL have port trig, output, 1 bit: single-cycle trigger pulse.
REQ-013 The block SHALL have port trig_code, output, 16 bits: payload qualifying trig.
REQ-014 The block SHALL have port busy, output, 1 bit: FSM not IDLE, or FIFO not empty.
REQ-015 The block SHALL have port overflow, output, 1 bit: sticky flag, a frame was dropped because the FIFO was full.
REQ-016 The block SHALL have port err, output, 1 bit: sticky flag, illegal opcode or ack timeout.

Function
REQ-017 Capture: rcv_succ SHALL pass through a 2-flop synchronizer; a rising edge of the synchronized signal SHALL push {command,data}, sampled on that same cycle, into the FIFO.
REQ-018 Capture: rcv_succ held high SHALL produce exactly one push.
REQ-019 Overflow: a push arriving when the FIFO holds FIFO_DEPTH entries (count at the start of the cycle) SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-020 FIFO: push and pop in the same cycle when not full SHALL leave the count unchanged.
REQ-021 FIFO: pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 FSM: the FSM SHALL have states IDLE, DECODE, ISSUE and WAIT_ACK.
REQ-023 FSM: from IDLE with the FIFO non-empty, the FSM SHALL pop the head entry and go to DECODE on the next cycle.
REQ-024 DECODE, command[7:4]==4'hA (write): reg_addr SHALL take command[3:0] and reg_wdata SHALL take data; the FSM SHALL go to ISSUE.
REQ-025 DECODE, command[7:4]==4'h5 (trigger): trig SHALL be 1 for exactly one cycle with trig_code=data; the FSM SHALL return to IDLE.
REQ-026 DECODE, command==8'h00 (NOP): the frame SHALL be discarded and the FSM SHALL return to IDLE.
REQ-027 DECODE, any other command: err SHALL be set and the FSM SHALL return to IDLE.
REQ-028 ISSUE: reg_wr_en SHALL assert; the FSM SHALL go to WAIT_ACK and clear the timeout counter.
REQ-029 WAIT_ACK: reg_wr_en, reg_addr and reg_wdata SHALL be held stable until reg_ack is sampled high.
REQ-030 WAIT_ACK: reg_wr_en SHALL deassert on the cycle after reg_ack is sampled high, and the FSM SHALL then go to IDLE.
REQ-031 WAIT_ACK: reg_ack already high in the first WAIT_ACK cycle SHALL complete the write.
REQ-032 Timeout: if reg_ack is not seen within ACK_TIMEOUT cycles in WAIT_ACK, reg_wr_en SHALL deassert, err SHALL be set and the FSM SHALL go to IDLE.
REQ-033 Throughput: at most one frame SHALL be in dispatch at a time.
REQ-034 Latency: the minimum latency from the synchronized rising edge to reg_wr_en high SHALL be 3 cycles (push, pop/DECODE, ISSUE).
REQ-035 Sticky flags: overflow and err SHALL be cleared only by rst.

Reset
REQ-036 When rst is asserted, reg_wr_en, trig, busy, overflow and err SHALL be 0; reg_addr, trig_code and reg_wdata SHALL be 0; the FIFO SHALL be emptied; the FSM SHALL be IDLE; the synchronizer SHALL be 0.
REQ-037 Reset asserted mid-WAIT_ACK SHALL drop reg_wr_en immediately (asynchronously) and discard the in-flight frame.
REQ-038 After reset deasserts, the first push SHALL require a new synchronized rising edge of rcv_succ.

Verification
REQ-039 Scenario, write: single frame command=8'hA3, data=16'h1234, reg_ack tied high -> one write with reg_addr=3 and reg_wdata=16'h1234, reg_wr_en high for 2 cycles, err=0.
REQ-040 Scenario, trigger: command=8'h51, data=16'hBEEF -> trig high for exactly 1 cycle with trig_code=16'hBEEF, and no reg_wr_en.
REQ-041 Scenario, overflow: reg_ack held low and 6 frames sent -> 1 in dispatch and 4 queued, one frame dropped, overflow=1; the remaining frames then complete in order once reg_ack is released.
REQ-042 Scenario, timeout: command=8'hA0 with reg_ack never asserted -> reg_wr_en falls after 255 cycles in WAIT_ACK, err=1, and the next queued frame is still dispatched.
REQ-043 Scenario, illegal opcode: command=8'h77 -> err=1, no reg_wr_en, no trig, and busy returns to 0.
REQ-044 Scenario, reset mid-operation: rst asserted during WAIT_ACK with 2 frames queued -> all outputs 0 on the same cycle, and after release busy=0 with no writes issued.
